output_blk: RTL and testbench



---
 rtl/output_blk.sv | 164 ++++++++++++++++
 tb/tb_output_blk.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_blk.sv
// output_blk: transmit-side host link. Result bytes from the core are queued
// in a small FIFO and serialised onto a UART line as 8N1 frames, with
// back-to-back frames sent without an idle gap.
module output_blk #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 100_000,
  parameter int DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       wr,
  output logic       tx,
  output logic       full,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW           = $clog2(CLKS_PER_BIT);
  localparam int PW           = $clog2(DEPTH);
  localparam int CW           = PW + 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic wr_en;
  logic pop;
  logic bit_end;

  // A write is dropped while full, even if a pop happens in the same cycle.
  assign wr_en   = wr && !full;
  // The head byte leaves the FIFO in the first cycle of the start bit; the
  // baud counter is only zero there once inside START.
  assign pop     = (state == S_START) && (baud_cnt == '0);
  assign bit_end = (baud_cnt == BIT_LAST);

  assign full = (count == COUNT_FULL);
  assign busy = (state != S_IDLE) || (count != '0);

  // FIFO storage write port.
  // NOTE: the storage array has no reset; count and pointers alone define
  // which entries are valid, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count as is.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit. tx is
  // registered and loaded on the same edge as each state/bit change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (count != '0) begin
            state    <= S_START;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
          end
        end

        S_START: begin
          // The popped byte is captured here, well before the first data
          // bit needs it, so later writes cannot disturb it.
          if (pop) begin
            shift <= mem[rd_ptr];
          end
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= S_DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (count != '0) begin
              // Chain straight into the next frame with no idle cycle.
              state   <= S_START;
              bit_idx <= '0;
              tx      <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_blk.sv
// tb_output_blk: self-checking bench for output_blk. A queue-and-timeline
// model predicts tx/busy/full every cycle, a UART decoder recovers the bytes
// and start-bit times, and directed scenarios pin literal cycle expectations.
module tb_output_blk;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;
  localparam int HMAX     = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr  = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx;
  logic       full;
  logic       busy;

  output_blk #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .wr  (wr),
    .tx  (tx),
    .full(full),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // FIFO contents as a queue; the frame in flight as a start cycle plus byte.
  logic [7:0] mq[$];
  logic [7:0] m_popped[$];
  bit         m_active = 1'b0;
  int         m_start  = 0;
  logic [7:0] m_byte   = 8'h00;
  int         m_sz;
  bit         m_act;

  function automatic bit m_in_frame(input int c);
    return m_active && (c >= m_start) && (c <= m_start + FRAME - 1);
  endfunction

  function automatic logic exp_tx(input int c);
    int k;
    if (!m_in_frame(c)) return 1'b1;
    k = (c - m_start) / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  // Model advance at each rising edge, then the cycle counter moves on.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
    end else begin
      m_sz  = mq.size();
      m_act = m_in_frame(cyc);
      if (m_act && cyc == m_start) begin
        m_byte = mq.pop_front();
        m_popped.push_back(m_byte);
      end
      if (wr && m_sz != DEPTH) mq.push_back(din);
      if (m_sz != 0 && (!m_act || cyc == m_start + FRAME - 1)) begin
        m_active = 1'b1;
        m_start  = cyc + 1;
      end else if (m_act && cyc == m_start + FRAME - 1) begin
        m_active = 1'b0;
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- history, compare and line decoder ----------------
  logic       h_tx   [HMAX];
  logic       h_busy [HMAX];
  logic       h_full [HMAX];
  int         rx_starts[$];
  logic [7:0] rx_bytes[$];
  bit         rx_busy = 1'b0;
  logic       rx_prev = 1'b1;
  int         rx_t0   = 0;
  int         rx_k;
  logic [7:0] rx_sh   = 8'h00;

  initial forever begin
    @(negedge clk);
    if (cyc < HMAX) begin
      h_tx[cyc]   = tx;
      h_busy[cyc] = busy;
      h_full[cyc] = full;
    end
    if (chk_en) begin
      check("tx",   tx,   exp_tx(cyc));
      check("busy", busy, m_in_frame(cyc) || mq.size() != 0);
      check("full", full, mq.size() == DEPTH);
      if (rst) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (rx_prev && !tx) begin
          rx_busy = 1'b1;
          rx_t0   = cyc;
          rx_starts.push_back(cyc);
        end
      end else if ((cyc - rx_t0) % CPB == CPB / 2) begin
        rx_k = (cyc - rx_t0) / CPB;
        if (rx_k == 0) begin
          check("rx_start_bit", tx, 0);
        end else if (rx_k <= 8) begin
          rx_sh[rx_k-1] = tx;
        end else begin
          check("rx_stop_bit", tx, 1);
          rx_bytes.push_back(rx_sh);
          rx_busy = 1'b0;
        end
      end
      rx_prev = tx;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_rx();
    rx_starts.delete();
    rx_bytes.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    wr  = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    clear_rx();
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    tick();
    wr  = 1'b0;
  endtask

  task automatic check_rx(input string name, input int idx, input int start, input logic [7:0] b);
    if (rx_starts.size() > idx) check({name, "_start"}, rx_starts[idx], start);
    else check({name, "_start_missing"}, rx_starts.size(), idx + 1);
    if (rx_bytes.size() > idx) check({name, "_byte"}, rx_bytes[idx], b);
    else check({name, "_byte_missing"}, rx_bytes.size(), idx + 1);
  endtask

  int t0;
  int late;
  int rate;

  initial begin
    // Reset: three cycles, then quiet line for 200 cycles.
    do_reset(3);
    chk_en = 1'b1;
    check("reset_tx",   tx,   1);
    check("reset_busy", busy, 0);
    check("reset_full", full, 0);
    idle(200);
    check("reset_no_start", rx_starts.size(), 0);

    // Single byte 0xA5.
    clear_rx();
    t0 = cyc;
    wr_byte(8'hA5);
    idle(109);
    check("single_busy_c0",   h_busy[t0],       0);
    check("single_busy_c1",   h_busy[t0+1],     1);
    check("single_tx_c1",     h_tx[t0+1],       1);
    check("single_tx_c2",     h_tx[t0+2],       0);
    check("single_tx_c11",    h_tx[t0+11],      0);
    check("single_tx_c12",    h_tx[t0+12],      1);
    check("single_tx_c22",    h_tx[t0+22],      0);
    check("single_tx_c32",    h_tx[t0+32],      1);
    check("single_tx_c91",    h_tx[t0+91],      1);
    check("single_tx_c92",    h_tx[t0+92],      1);
    check("single_busy_c101", h_busy[t0+101],   1);
    check("single_busy_c102", h_busy[t0+102],   0);
    check("single_frames",    rx_bytes.size(),  1);
    check_rx("single", 0, t0 + 2, 8'hA5);

    // Burst of three contiguous frames.
    clear_rx();
    t0 = cyc;
    wr_byte(8'h00);
    wr_byte(8'hFF);
    wr_byte(8'h55);
    idle(310);
    check("burst_frames", rx_bytes.size(), 3);
    check_rx("burst0", 0, t0 + 2,   8'h00);
    check_rx("burst1", 1, t0 + 102, 8'hFF);
    check_rx("burst2", 2, t0 + 202, 8'h55);
    check("burst_busy_c301", h_busy[t0+301], 1);
    check("burst_busy_c302", h_busy[t0+302], 0);

    // Overflow: sixth byte dropped.
    clear_rx();
    t0 = cyc;
    for (int i = 1; i <= 6; i++) wr_byte(8'(i));
    idle(510);
    check("ovf_full_c4",   h_full[t0+4],   0);
    check("ovf_full_c5",   h_full[t0+5],   1);
    check("ovf_full_c102", h_full[t0+102], 1);
    check("ovf_full_c103", h_full[t0+103], 0);
    check("ovf_frames",    rx_bytes.size(), 5);
    for (int i = 0; i < 5; i++) check_rx("ovf", i, t0 + 2 + i * FRAME, 8'(i + 1));

    // Write during the stop bit chains the next frame without a gap.
    clear_rx();
    t0 = cyc;
    wr_byte(8'h3C);
    idle(94);
    wr_byte(8'hC3);
    idle(210);
    check("stopwr_tx_c101", h_tx[t0+101], 1);
    check("stopwr_tx_c102", h_tx[t0+102], 0);
    check("stopwr_frames",  rx_bytes.size(), 2);
    check_rx("stopwr0", 0, t0 + 2,   8'h3C);
    check_rx("stopwr1", 1, t0 + 102, 8'hC3);

    // Reset mid-frame aborts the frame and discards the queue.
    clear_rx();
    t0 = cyc;
    wr_byte(8'h11);
    wr_byte(8'h22);
    idle(48);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(300);
    check("rstmid_tx_c50",   h_tx[t0+50],   0);
    check("rstmid_tx_c51",   h_tx[t0+51],   1);
    check("rstmid_busy_c51", h_busy[t0+51], 0);
    check("rstmid_full_c51", h_full[t0+51], 0);
    late = 0;
    foreach (rx_starts[i]) if (rx_starts[i] > t0 + 50) late++;
    check("rstmid_late_starts", late, 0);
    check("rstmid_frames",      rx_bytes.size(), 0);

    // Randomised traffic with varying write density, then drain.
    clear_rx();
    m_popped.delete();
    for (int seg = 0; seg < 60; seg++) begin
      rate = $urandom_range(0, 3);
      for (int i = 0; i < 50; i++) begin
        if (rate == 3)      wr = 1'b1;
        else if (rate == 0) wr = 1'b0;
        else                wr = ($urandom_range(0, (rate == 1) ? 19 : 2) == 0);
        din = 8'($urandom);
        tick();
      end
    end
    wr = 1'b0;
    idle((DEPTH + 2) * FRAME);
    check("rand_idle_busy", busy, 0);
    check("rand_frames", rx_bytes.size(), m_popped.size());
    for (int i = 0; i < rx_bytes.size() && i < m_popped.size(); i++)
      check("rand_byte", rx_bytes[i], m_popped[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
